// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared constants, state encoding and address layout for the calibration loader
package cal_pkg;

  localparam int unsigned N_CHANNELS = 8;
  localparam int unsigned CAL_WORDS  = 2 * N_CHANNELS;

  localparam logic [7:0] SYNC_BYTE = 8'hCA;

  // Coefficient word address is {channel, sel}: even words hold shift, odd words hold multiply.
  localparam logic ADDR_SHIFT_SEL = 1'b0;
  localparam logic ADDR_MULT_SEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    CHECK   = 3'd2,
    ARM     = 3'd3,
    COMMIT  = 3'd4
  } cal_ld_state_t;

endpackage

// File: rtl/cal_loader.sv
// rtl/cal_loader.sv - framed byte stream to calibration RAM loader, sample-aligned commit (optional CAL_LOADER_TIMEOUT_EN)
module cal_loader
  import cal_pkg::*;
#(
  parameter int unsigned W              = 16,
  parameter int unsigned N_CHANNELS     = cal_pkg::N_CHANNELS,
  parameter logic [7:0]  SYNC_BYTE      = cal_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sample_clk,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              cal_we,
  output logic [$clog2(2*N_CHANNELS)-1:0]   cal_waddr,
  output logic [W-1:0]                      cal_wdata,
  output logic                              done,
  output logic                              err
);

  localparam int unsigned WORDS = 2 * N_CHANNELS;
  localparam int unsigned AW    = $clog2(WORDS);
  localparam int unsigned IW    = AW + 1;
  localparam int unsigned BPW   = W / 8;
  localparam int unsigned BW    = (BPW > 1) ? $clog2(BPW) : 1;

  cal_ld_state_t r_state, w_state_nxt;

  logic          r_sclk_l;
  logic [IW-1:0] r_word, w_word_nxt;
  logic [BW-1:0] r_bsel, w_bsel_nxt;
  logic [7:0]    r_sum, w_sum_nxt, w_sum_add;
  logic          r_in_ready, w_in_ready_nxt;
  logic          r_we, w_we_nxt;
  logic [AW-1:0] r_waddr, w_waddr_nxt;
  logic [W-1:0]  r_wdata, w_wdata_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          w_store;
  logic          w_accept;
  logic          w_rise;
  logic          w_to_fire;

  logic [W-1:0]  r_shadow [WORDS];

  assign w_accept  = in_valid && r_in_ready;
  assign w_rise    = sample_clk && !r_sclk_l;
  assign w_sum_add = r_sum + in_data;

`ifdef CAL_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt, w_to_nxt;

  // Count idle cycles while a frame is open; fire when the gap reaches the limit.
  always_comb begin
    w_to_nxt  = '0;
    w_to_fire = 1'b0;
    if ((r_state == PAYLOAD || r_state == CHECK) && !w_accept) begin
      if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        w_to_fire = 1'b1;
      end else begin
        w_to_nxt = r_to_cnt + 1'b1;
      end
    end
  end

  // Inter-byte gap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_nxt;
    end
  end
`else
  assign w_to_fire = 1'b0;
`endif

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_bsel_nxt  = r_bsel;
    w_sum_nxt   = r_sum;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_store     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept && in_data == SYNC_BYTE) begin
          w_state_nxt = PAYLOAD;
          w_word_nxt  = '0;
          w_bsel_nxt  = '0;
          w_sum_nxt   = '0;
        end
      end

      PAYLOAD: begin
        if (w_accept) begin
          w_store   = 1'b1;
          w_sum_nxt = w_sum_add;
          if (r_bsel == BW'(BPW - 1)) begin
            w_bsel_nxt = '0;
            w_word_nxt = r_word + 1'b1;
            if (r_word == IW'(WORDS - 1)) begin
              w_state_nxt = CHECK;
            end
          end else begin
            w_bsel_nxt = r_bsel + 1'b1;
          end
        end
      end

      CHECK: begin
        if (w_accept) begin
          if (w_sum_add == 8'd0) begin
            w_state_nxt = ARM;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end

      // The first write is issued from the edge cycle so it lands one cycle later.
      ARM: begin
        if (w_rise) begin
          w_state_nxt = COMMIT;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = '0;
          w_wdata_nxt = r_shadow[0];
          w_word_nxt  = IW'(1);
        end
      end

      COMMIT: begin
        if (r_word == IW'(WORDS)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_word[AW-1:0];
          w_wdata_nxt = r_shadow[r_word[AW-1:0]];
          w_word_nxt  = r_word + 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (w_to_fire) begin
      w_state_nxt = IDLE;
      w_err_nxt   = 1'b1;
    end

    w_in_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == PAYLOAD) || (w_state_nxt == CHECK);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sclk_l   <= 1'b0;
      r_word     <= '0;
      r_bsel     <= '0;
      r_sum      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sclk_l   <= sample_clk;
      r_word     <= w_word_nxt;
      r_bsel     <= w_bsel_nxt;
      r_sum      <= w_sum_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_we       <= w_we_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Shadow buffer fill, big-endian: first byte of a word goes to its top lane.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_shadow[r_word[AW-1:0]][8*(BPW-1-int'(r_bsel)) +: 8] <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign cal_we    = r_we;
  assign cal_waddr = r_waddr;
  assign cal_wdata = r_wdata;
  assign done      = r_done;
  assign err       = r_err;

endmodule
